// File: rtl/pila_pkg.sv
// pila_pkg: shared op encoding and default geometry for the parametrised stack.
package pila_pkg;
  localparam int PILA_WIDTH = 10;
  localparam int PILA_DEPTH = 16;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;
endpackage

// File: rtl/pila_param_if.sv
// pila_param_if: command/data/status bundle between a stack user and the stack.
interface pila_param_if import pila_pkg::*; #(
  parameter int WIDTH = PILA_WIDTH,
  parameter int DEPTH = PILA_DEPTH
) ();
  localparam int NW = $clog2(DEPTH + 1);
  logic             push;
  logic             pop;
  logic             flush;
  logic [WIDTH-1:0] entrada;
  logic [WIDTH-1:0] salida;
  logic [NW-1:0]    nivel;
  logic             vacio;
  logic             lleno;
  logic             overflow;
  logic             underflow;
  modport master (
    output push, pop, flush, entrada,
    input  salida, nivel, vacio, lleno, overflow, underflow
  );
  modport slave (
    input  push, pop, flush, entrada,
    output salida, nivel, vacio, lleno, overflow, underflow
  );
endinterface

// File: rtl/mempila_param.sv
// mempila_param: stack storage, one synchronous write port and one asynchronous read port.
module mempila_param #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/pila_param.sv
// pila_param: parametrised LIFO with combinational top, occupancy flags and sticky errors.
module pila_param import pila_pkg::*; #(
  parameter int WIDTH = PILA_WIDTH,
  parameter int DEPTH = PILA_DEPTH
) (
  input logic         clk,
  input logic         reset,
  pila_param_if.slave bus
);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [NW-1:0]    sp, sp_n;
  logic             ov, ov_n, un, un_n, we, empty, full;
  logic [1:0]       op;
  logic [AW-1:0]    top_a, wa;
  logic [WIDTH-1:0] rd;
  assign op    = {bus.push, bus.pop};
  assign empty = sp == '0;
  assign full  = sp == NW'(DEPTH);
  assign top_a = AW'(sp - NW'(1));
  assign wa    = op == OP_REPL ? top_a : AW'(sp);
  // sp only moves when the op is legal, so it stays within 0..DEPTH without wrapping
  always_comb begin
    sp_n = sp;
    ov_n = ov;
    un_n = un;
    we   = 1'b0;
    if (bus.flush) begin
      sp_n = '0;
      ov_n = 1'b0;
      un_n = 1'b0;
    end else begin
      case (op)
        OP_NOP: ;
        OP_PUSH: if (full) ov_n = 1'b1; else begin we = 1'b1; sp_n = sp + NW'(1); end
        OP_POP:  if (empty) un_n = 1'b1; else sp_n = sp - NW'(1);
        OP_REPL: if (empty) un_n = 1'b1; else we = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sp <= '0;
      ov <= 1'b0;
      un <= 1'b0;
    end else begin
      sp <= sp_n;
      ov <= ov_n;
      un <= un_n;
    end
  mempila_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wa),
    .wdata (bus.entrada),
    .raddr (top_a),
    .rdata (rd)
  );
  // masking the empty case keeps never-written array cells off the output
  assign bus.salida    = empty ? '0 : rd;
  assign bus.nivel     = sp;
  assign bus.vacio     = empty;
  assign bus.lleno     = full;
  assign bus.overflow  = ov;
  assign bus.underflow = un;
endmodule

// File: tb/tb_pila_param.sv
// tb_pila_param: directed plus random stack ops checked against a queue-based reference stack.
module tb_pila_param;
  localparam int W = 10;
  localparam int D = 4;
  typedef struct {
    logic [31:0] salida;
    logic [31:0] nivel;
    logic        vacio;
    logic        lleno;
    logic        ov;
    logic        un;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   stk[$];
  logic m_ov = 1'b0;
  logic m_un = 1'b0;
  exp_t sb[$];
  always #5 clk = ~clk;
  pila_param_if #(.WIDTH(W), .DEPTH(D)) bus ();
  pila_param #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_top();
    return stk.size() > 0 ? stk[$] : 0;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.salida = model_top();
    e.nivel  = stk.size();
    e.vacio  = stk.size() == 0;
    e.lleno  = stk.size() == D;
    e.ov     = m_ov;
    e.un     = m_un;
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_salida"}, bus.salida, e.salida);
    chk({tag, "_nivel"}, bus.nivel, e.nivel);
    chk({tag, "_vacio"}, bus.vacio, e.vacio);
    chk({tag, "_lleno"}, bus.lleno, e.lleno);
    chk({tag, "_overflow"}, bus.overflow, e.ov);
    chk({tag, "_underflow"}, bus.underflow, e.un);
  endtask

  task automatic step(input string tag, input logic pu, input logic po, input logic fl, input logic [W-1:0] d);
    @(negedge clk);
    bus.push = pu;
    bus.pop = po;
    bus.flush = fl;
    bus.entrada = d;
    #1;
    chk({tag, "_pre_top"}, bus.salida, model_top());
    if (fl) begin
      stk.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (pu && po) begin
      if (stk.size() == 0) m_un = 1'b1; else stk[stk.size()-1] = int'(d);
    end else if (pu) begin
      if (stk.size() == D) m_ov = 1'b1; else stk.push_back(int'(d));
    end else if (po) begin
      if (stk.size() == 0) m_un = 1'b1; else void'(stk.pop_back());
    end
    sb.push_back(snap());
    @(posedge clk);
    #1;
    compare(tag);
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.flush = 1'b0;
    bus.entrada = '0;
    @(posedge clk);
    #1;
    chk("rst_salida", bus.salida, 0);
    chk("rst_nivel", bus.nivel, 0);
    chk("rst_vacio", bus.vacio, 1);
    chk("rst_lleno", bus.lleno, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_underflow", bus.underflow, 0);
    @(negedge clk);
    reset = 1'b1;
    step("push_a", 1, 0, 0, 10'h155);
    step("push_b", 1, 0, 0, 10'h0AA);
    step("push_c", 1, 0, 0, 10'h3FF);
    chk("basic_top", bus.salida, 'h3FF);
    chk("basic_nivel", bus.nivel, 3);
    step("pop_a", 0, 1, 0, '0);
    chk("pop_a_top", bus.salida, 'h0AA);
    step("pop_b", 0, 1, 0, '0);
    chk("pop_b_top", bus.salida, 'h155);
    step("pop_c", 0, 1, 0, '0);
    chk("pop_c_vacio", bus.vacio, 1);
    for (int i = 1; i <= 4; i++) step("fill", 1, 0, 0, W'(i));
    chk("fill_lleno", bus.lleno, 1);
    step("ovf_push", 1, 0, 0, 10'd5);
    chk("ovf_top", bus.salida, 4);
    chk("ovf_flag", bus.overflow, 1);
    step("ovf_pop", 0, 1, 0, '0);
    chk("ovf_pop_top", bus.salida, 3);
    step("flush_push", 1, 0, 1, 10'h3CC);
    chk("flush_nivel", bus.nivel, 0);
    chk("flush_ov", bus.overflow, 0);
    step("unf_pop", 0, 1, 0, '0);
    chk("unf_flag", bus.underflow, 1);
    step("unf_repl", 1, 1, 0, 10'h123);
    chk("unf_repl_nivel", bus.nivel, 0);
    step("unf_push", 1, 0, 0, 10'h00F);
    chk("unf_push_top", bus.salida, 'h00F);
    step("drain", 0, 1, 0, '0);
    step("repl_p1", 1, 0, 0, 10'd1);
    step("repl_p2", 1, 0, 0, 10'd2);
    step("repl", 1, 1, 0, 10'h2A0);
    chk("repl_top", bus.salida, 'h2A0);
    chk("repl_nivel", bus.nivel, 2);
    step("repl_pop", 0, 1, 0, '0);
    chk("repl_pop_top", bus.salida, 1);
    step("full_p2", 1, 0, 0, 10'd2);
    step("full_p3", 1, 0, 0, 10'd3);
    step("full_p4", 1, 0, 0, 10'd4);
    step("full_repl", 1, 1, 0, 10'h155);
    chk("full_repl_top", bus.salida, 'h155);
    chk("full_repl_lleno", bus.lleno, 1);
    chk("full_repl_ov", bus.overflow, 0);
    step("ar_pop1", 0, 1, 0, '0);
    step("ar_pop2", 0, 1, 0, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_salida", bus.salida, 0);
    chk("arst_nivel", bus.nivel, 0);
    chk("arst_vacio", bus.vacio, 1);
    chk("arst_underflow", bus.underflow, 0);
    stk.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    #1;
    reset = 1'b1;
    step("arst_push", 1, 0, 0, 10'h111);
    chk("arst_push_top", bus.salida, 'h111);
    for (int i = 0; i < 80; i++)
      step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, W'($urandom_range(0, 1023)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pila_param.md
Name: pila_param

Overview:
- Parametrised hardware stack: the next-generation return-address/data stack for the monocycle CPU and its I/O extensions.
- Generalises the fixed 10-bit stack in width and depth.
- Adds full/empty flags, an occupancy count and sticky overflow/underflow errors.
- Adds simultaneous push+pop (replace top) and a synchronous flush.
- Top of stack is visible combinationally, so a single-cycle return reads it in the same cycle as the pop.

Parameters:
- WIDTH, 10, data word width in bits (≥1).
- DEPTH, 16, number of entries (≥2, need not be a power of two).
- NW, $clog2(DEPTH+1), derived localparam: width of stack pointer and count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- push  input  1  push entrada this cycle.
- pop  input  1  pop top this cycle.
- flush  input  1  synchronous empty-stack and error clear.
- entrada  input  WIDTH  data to push.
- salida  output  WIDTH  current top of stack (combinational).
- nivel  output  NW  number of valid entries, 0..DEPTH.
- vacio  output  1  nivel==0.
- lleno  output  1  nivel==DEPTH.
- overflow  output  1  sticky: push rejected because stack full.
- underflow  output  1  sticky: pop rejected because stack empty.

Behaviour:
- Reset (reset low, asynchronous):
  - sp=0, overflow=0, underflow=0; hence nivel=0, vacio=1, lleno=0, salida=0.
  - Storage array is not reset.
- Storage: DEPTH×WIDTH array, one synchronous write port, one asynchronous read port.
- sp points at the next free slot; nivel=sp.
- salida = mem[sp-1] when sp>0, else all zeros.
- Priority per rising edge: flush > push/pop decode.
  - flush=1: sp←0, overflow←0, underflow←0; push/pop ignored that cycle; array untouched.
- Op decode, with flush=0:
  - push=0, pop=0: hold.
  - push=1, pop=0, sp<DEPTH: mem[sp]←entrada, sp←sp+1.
  - push=1, pop=0, sp==DEPTH: no write, sp held, overflow←1.
  - push=0, pop=1, sp>0: sp←sp-1. The old top was visible on salida during this cycle.
  - push=0, pop=1, sp==0: sp held, underflow←1.
  - push=1, pop=1, sp>0: replace top. mem[sp-1]←entrada, sp unchanged; legal also when full.
  - push=1, pop=1, sp==0: whole op rejected, no write, underflow←1.
- Error flags stay set until reset or flush; they never block later legal operations.
- Latency:
  - Pushed data appears on salida the cycle after the push edge.
  - nivel, vacio and lleno update on the same edge as sp.
- Pointer arithmetic is saturating by construction: sp never leaves 0..DEPTH and never wraps.
- Reset asserted mid-sequence discards all contents logically: sp=0, salida=0 immediately, without waiting for a clock edge.
- No X propagation: salida is forced to 0 when empty, so uninitialised array reads are never exposed.

Decomposition:
- Shared package pila_pkg:
  - Op encoding localparams OP_NOP=2'b00, OP_POP=2'b01, OP_PUSH=2'b10, OP_REPL=2'b11, with op={push,pop}.
  - Default WIDTH/DEPTH constants for the CPU build.
- Sub-module mempila_param#(WIDTH,DEPTH): write enable, write address, write data, async read address and read data.
- Pointer/flag logic lives in pila_param; the existing sumres/registro/mux2 style parts may be reused for the sp path.

Test Plan:
- Basic push then pop, WIDTH=10, DEPTH=4:
  - Reset, then push 0x155, 0x0AA, 0x3FF → nivel=3, salida=0x3FF.
  - Three pops → salida shows 0x0AA, 0x155 after successive edges, then 0 with vacio=1.
- Fill and overflow:
  - Push 1,2,3,4 → lleno=1, nivel=4.
  - Push 5 → nivel stays 4, salida=4, overflow=1.
  - Pop → salida=3, overflow still 1.
- Underflow:
  - From empty, pop → underflow=1, nivel=0.
  - Push+pop on empty → no write, nivel=0, underflow stays 1.
  - Then push 0x00F → nivel=1, salida=0x00F.
- Replace top:
  - Stack {1,2}: push+pop with entrada=0x2A0 → nivel=2, salida=0x2A0.
  - Pop → salida=1.
  - Repeat at full (DEPTH=4) → lleno stays 1, overflow stays 0.
- Flush priority:
  - Stack of 3 with overflow=1: assert flush with push=1 → nivel=0, vacio=1, overflow=0, underflow=0, no write.
- Asynchronous reset mid-operation:
  - Stack of 2: drop reset between clock edges → salida=0, nivel=0, vacio=1 before the next edge.
  - Release reset, push 0x111 → salida=0x111, nivel=1.
